scarv_soc_periph_xbar: RTL and testbench
========================================

# scarv_soc_periph_xbar

Parametrised peripheral-subsystem router: takes one requestor memory port and fans it out to up to 16 peripheral devices, each occupying a 4 KB slot in a 64 KB window. Tracks outstanding transactions in an in-order ID FIFO so pipelined requests to different devices return in issue order. Answers unmapped or disabled slots with an error response. Sits between the SoC interconnect and the peripheral devices (UART, GPIO, timers, …).

## Interface
- NDEV, 2: number of device ports, 1..16; device i owns slot i.
- BASE, 32'h1000_0000: window base; only addr[31:16] is compared.
- SLOT_EN, 16'h0003: bit i set means slot i is mapped; only bits below NDEV are honoured.
- DEPTH, 4: maximum outstanding transactions, power of two, 2..16.
- g_clk  in  1  single clock for all logic.
- g_resetn  in  1  synchronous, active-low reset.
- core_req / core_gnt  in / out  1 / 1  request handshake; a transfer happens when both are high.
- core_wen, core_strb, core_addr, core_wdata  in  1, 4, 32, 32  request payload.
- core_rsp / core_ack  out / in  1 / 1  response handshake; completes when both are high.
- core_error, core_rdata  out  1, 32  response payload.
- dev_req / dev_gnt  out / in  NDEV / NDEV  per-device request handshake.
- dev_wen, dev_strb, dev_addr, dev_wdata  out  1, 4, 32, 32  broadcast copy of core payload.
- dev_rsp / dev_ack  in / out  NDEV / NDEV  per-device response handshake.
- dev_error, dev_rdata  in  NDEV, NDEV*32  per-device response payload; device i uses bits [32i+31:32i].
- busy  out  1  high while the FIFO is non-empty.
- unmapped_pulse  out  1  one-cycle pulse when an unmapped request is accepted.

## Operation
- Decode: hit = addr[31:16]==BASE[31:16]. slot = addr[15:12]. The request is mapped when hit, slot<NDEV and SLOT_EN[slot] are all true. Otherwise the target is ID_ERR (= NDEV).
- Request path (combinational): dev_req[slot] = core_req & mapped & !full; all other dev_req bits are 0. core_gnt = !full & (mapped ? dev_gnt[slot] : 1).
- Accept (core_req & core_gnt): push the target ID (slot or ID_ERR) into the FIFO. For an unmapped request, also pulse unmapped_pulse.
- Response path: only the head ID is served.
  - Head is device d: core_rsp = dev_rsp[d], core_error = dev_error[d], core_rdata = dev_rdata[d], dev_ack[d] = core_ack.
  - Head is ID_ERR: core_rsp = 1, core_error = 1, core_rdata = 0.
  - FIFO empty: core_rsp = 0.
- Response completion (core_rsp & core_ack) pops the FIFO.
- Non-head devices always see dev_ack = 0. Their dev_rsp is held off and is not visible to the core.
- Full (count==DEPTH): core_gnt = 0, dev_req = 0; a pop in that cycle does not bypass.
- Push and pop in the same cycle when not full: count unchanged, pointers both advance; pointers wrap modulo DEPTH.
- Reset: FIFO is emptied and pointers/count go to 0; in-flight transactions are discarded, and devices are reset by the same g_resetn.
- Reset values: core_gnt=0, core_rsp=0, core_error=0, core_rdata=0, dev_req=0, dev_ack=0, busy=0, unmapped_pulse=0.

## Timing
- Request routing: zero cycles; core_gnt follows dev_gnt combinationally.
- Device response: zero cycles, once that transaction is at the FIFO head.
- ID_ERR response: earliest the cycle after acceptance; held until acked.
- Back-to-back accepts: one per cycle up to DEPTH.
- count, pointers, busy and unmapped_pulse are registered.

## Structure
- Package scarv_soc_periph_pkg holds:
  - SLOT_BITS=12 and WINDOW_BITS=16;
  - the periph_id_t typedef (5 bits, holds 0..16);
  - the ID_ERR helper;
  - the slot-decode function.
- Sub-module scarv_soc_periph_idfifo: synchronous FIFO of periph_id_t, DEPTH entries, push/pop/full/empty/head.

## Test plan
- Mapped read: NDEV=2, read 0x1000_1004; device 1 grants immediately and responds the next cycle with rdata 0xA5A5_0001 -> core gets rdata 0xA5A5_0001, error 0, busy high for 1 cycle.
- Ordering: read slot 1 then slot 0 back-to-back; device 0 responds first -> core sees device 1 data first, then device 0; dev_ack[0] stays 0 until slot 1 pops.
- Unmapped: write to 0x1000_5000 (slot 5, disabled) and separately to 0x2000_0000 -> immediate gnt, unmapped_pulse once each, responses error=1, rdata=0.
- Full: DEPTH=4, 4 requests accepted with devices withholding rsp -> 5th request sees core_gnt=0 and dev_req=0; after one pop, gnt returns the following cycle.
- Simultaneous push/pop at count=2 -> count stays 2; ordering of subsequent responses preserved across pointer wrap.
- Reset with 3 outstanding -> next cycle busy=0, core_rsp=0, all outputs at their reset values; a fresh read completes normally.

Source files
------------

// File: rtl/scarv_soc_periph_xbar_pkg.sv
// Shared types and address-decode helpers for the peripheral router.
// Slot decode is purely combinational; no state lives here.
package scarv_soc_periph_pkg;

  localparam int SLOT_BITS   = 12;
  localparam int WINDOW_BITS = 16;

  typedef logic [4:0] periph_id_t;

  function automatic periph_id_t id_err(input int ndev);
    return periph_id_t'(ndev);
  endfunction

  // Returns the owning slot, or the error ID for anything outside the enabled slots.
  function automatic periph_id_t decode_slot(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int          ndev,
    input logic [15:0] slot_en
  );
    logic [3:0] slot;
    slot = addr[SLOT_BITS +: 4];
    if ((addr[31:WINDOW_BITS] == base[31:WINDOW_BITS]) && (int'(slot) < ndev) && slot_en[slot])
      return {1'b0, slot};
    return id_err(ndev);
  endfunction

endpackage

// File: rtl/scarv_soc_periph_xbar_if.sv
// Core-side and device-side request/response bundle for the peripheral router.
// slave is the router's view; master is the surrounding requestor plus devices.
interface scarv_soc_periph_xbar_if #(parameter int NDEV = 2);
  logic                 core_req, core_gnt, core_wen;
  logic [3:0]           core_strb;
  logic [31:0]          core_addr, core_wdata;
  logic                 core_rsp, core_ack, core_error;
  logic [31:0]          core_rdata;
  logic [NDEV-1:0]      dev_req, dev_gnt;
  logic                 dev_wen;
  logic [3:0]           dev_strb;
  logic [31:0]          dev_addr, dev_wdata;
  logic [NDEV-1:0]      dev_rsp, dev_ack, dev_error;
  logic [NDEV*32-1:0]   dev_rdata;
  logic                 busy, unmapped_pulse;

  modport slave (
    input  core_req, core_wen, core_strb, core_addr, core_wdata, core_ack,
    output core_gnt, core_rsp, core_error, core_rdata,
    input  dev_gnt, dev_rsp, dev_error, dev_rdata,
    output dev_req, dev_wen, dev_strb, dev_addr, dev_wdata, dev_ack,
    output busy, unmapped_pulse
  );

  modport master (
    output core_req, core_wen, core_strb, core_addr, core_wdata, core_ack,
    input  core_gnt, core_rsp, core_error, core_rdata,
    output dev_gnt, dev_rsp, dev_error, dev_rdata,
    input  dev_req, dev_wen, dev_strb, dev_addr, dev_wdata, dev_ack,
    input  busy, unmapped_pulse
  );
endinterface

// File: rtl/scarv_soc_periph_idfifo.sv
// In-order FIFO of target IDs; head is visible combinationally, push/pop take effect at the clock.
// Push is ignored when full and pop is ignored when empty.
module scarv_soc_periph_idfifo
  import scarv_soc_periph_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       g_clk,
  input  logic       g_resetn,
  input  logic       i_push,
  input  periph_id_t i_push_id,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output periph_id_t o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

  periph_id_t    r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count;
  logic          w_push, w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge g_clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_id;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end

endmodule

// File: rtl/scarv_soc_periph_xbar.sv
// Routes one requestor port to NDEV peripheral slots, returning responses in issue order.
// Zero-cycle request/response routing; stalls the requestor while DEPTH transactions are outstanding.
module scarv_soc_periph_xbar
  import scarv_soc_periph_pkg::*;
#(
  parameter int          NDEV    = 2,
  parameter logic [31:0] BASE    = 32'h1000_0000,
  parameter logic [15:0] SLOT_EN = 16'h0003,
  parameter int          DEPTH   = 4
) (
  input logic                    g_clk,
  input logic                    g_resetn,
  scarv_soc_periph_xbar_if.slave bus
);

  localparam periph_id_t ID_ERR = id_err(NDEV);

  periph_id_t w_tgt, w_head;
  logic       w_mapped, w_full, w_empty, w_accept, w_done;
  logic       r_unmapped;

  assign w_tgt    = decode_slot(bus.core_addr, BASE, NDEV, SLOT_EN);
  assign w_mapped = (w_tgt != ID_ERR);
  assign w_accept = bus.core_req & bus.core_gnt;
  assign w_done   = bus.core_rsp & bus.core_ack;

  assign bus.dev_wen        = bus.core_wen;
  assign bus.dev_strb       = bus.core_strb;
  assign bus.dev_addr       = bus.core_addr;
  assign bus.dev_wdata      = bus.core_wdata;
  assign bus.busy           = ~w_empty;
  assign bus.unmapped_pulse = r_unmapped;

  scarv_soc_periph_idfifo #(.DEPTH(DEPTH)) u_idfifo (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .i_push    (w_accept),
    .i_push_id (w_tgt),
    .i_pop     (w_done),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_head    (w_head)
  );

  // Outputs are held at their idle values while reset is asserted.
  always_comb begin
    bus.dev_req    = '0;
    bus.dev_ack    = '0;
    bus.core_gnt   = 1'b0;
    bus.core_rsp   = 1'b0;
    bus.core_error = 1'b0;
    bus.core_rdata = '0;
    if (g_resetn) begin
      if (!w_full) begin
        if (!w_mapped) bus.core_gnt = 1'b1;
        for (int i = 0; i < NDEV; i++) begin
          if (w_mapped && (w_tgt == periph_id_t'(i))) begin
            bus.dev_req[i] = bus.core_req;
            bus.core_gnt   = bus.dev_gnt[i];
          end
        end
      end
      if (!w_empty) begin
        if (w_head == ID_ERR) begin
          bus.core_rsp   = 1'b1;
          bus.core_error = 1'b1;
        end
        for (int i = 0; i < NDEV; i++) begin
          if (w_head == periph_id_t'(i)) begin
            bus.core_rsp   = bus.dev_rsp[i];
            bus.core_error = bus.dev_error[i];
            bus.core_rdata = bus.dev_rdata[32*i +: 32];
            bus.dev_ack[i] = bus.core_ack;
          end
        end
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) r_unmapped <= 1'b0;
    else           r_unmapped <= w_accept & ~w_mapped;
  end

endmodule

// File: tb/tb_scarv_soc_periph_xbar.sv
// Directed and random traffic against a queue-based reference of the peripheral router.
module tb_scarv_soc_periph_xbar;

  localparam int          NDEV    = 2;
  localparam int          DEPTH   = 4;
  localparam logic [15:0] SLOT_EN = 16'h0003;
  localparam int          ERR     = NDEV;

  logic g_clk = 1'b0;
  logic g_resetn;
  int   n_chk = 0;
  int   n_err = 0;
  int   q[$];
  logic [31:0] dr [NDEV];

  scarv_soc_periph_xbar_if #(.NDEV(NDEV)) bus ();

  scarv_soc_periph_xbar #(
    .NDEV(NDEV), .BASE(32'h1000_0000), .SLOT_EN(SLOT_EN), .DEPTH(DEPTH)
  ) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus)
  );

  initial forever #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Target of an address straight from the memory map: 64 KB window at 0x1000_0000, 4 KB slots.
  function automatic int route(input logic [31:0] a);
    int s;
    s = int'((a >> 12) & 32'hF);
    if ((a >> 16) == 32'h1000 && s < NDEV && SLOT_EN[s]) return s;
    return ERR;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'h1000_0000 | ($urandom & 32'hFFC);
      1:       return 32'h1000_1000 | ($urandom & 32'hFFC);
      2:       return 32'h1000_0000 | (32'($urandom_range(2, 15)) << 12);
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: drive after negedge, check combinational outputs, clock, check registered outputs.
  task automatic step(input bit req, input logic [31:0] addr, input logic [1:0] gnt,
                      input logic [1:0] rsp, input logic [1:0] err, input bit ack);
    int  tgt, head;
    bit  full, acc, done, e_gnt, e_rsp, e_err;
    logic [1:0]  e_req, e_ack;
    logic [31:0] e_rdata;
    bus.core_req   = req;
    bus.core_addr  = addr;
    bus.core_wen   = 1'($urandom);
    bus.core_strb  = 4'($urandom);
    bus.core_wdata = $urandom;
    bus.core_ack   = ack;
    bus.dev_gnt    = gnt;
    bus.dev_rsp    = rsp;
    bus.dev_error  = err;
    bus.dev_rdata  = {dr[1], dr[0]};
    #1;
    tgt   = route(addr);
    full  = (q.size() == DEPTH);
    e_gnt = !full && (tgt == ERR || gnt[tgt]);
    e_req = (!full && req && tgt != ERR) ? 2'(1 << tgt) : 2'b00;
    e_rsp = 1'b0; e_err = 1'b0; e_rdata = '0; e_ack = 2'b00;
    if (q.size() != 0) begin
      head = q[0];
      if (head == ERR) begin
        e_rsp = 1'b1; e_err = 1'b1;
      end else begin
        e_rsp = rsp[head]; e_err = err[head]; e_rdata = dr[head];
        e_ack = ack ? 2'(1 << head) : 2'b00;
      end
    end
    chk("core_gnt", bus.core_gnt, e_gnt);
    chk("dev_req", bus.dev_req, e_req);
    chk("dev_addr", bus.dev_addr, addr);
    chk("core_rsp", bus.core_rsp, e_rsp);
    chk("dev_ack", bus.dev_ack, e_ack);
    if (q.size() != 0) begin
      chk("core_error", bus.core_error, e_err);
      chk("core_rdata", bus.core_rdata, e_rdata);
    end
    acc  = req && e_gnt;
    done = e_rsp && ack;
    @(posedge g_clk);
    if (done) void'(q.pop_front());
    if (acc) q.push_back(tgt);
    #1;
    chk("busy", bus.busy, q.size() != 0);
    chk("unmapped_pulse", bus.unmapped_pulse, acc && tgt == ERR);
    @(negedge g_clk);
  endtask

  task automatic do_reset();
    g_resetn     = 1'b0;
    bus.core_req = 1'b1;
    bus.core_addr = 32'h2000_0000;
    bus.core_ack = 1'b1;
    bus.dev_gnt  = 2'b11;
    bus.dev_rsp  = 2'b11;
    #1;
    chk("rst_core_gnt", bus.core_gnt, 0);
    chk("rst_core_rsp", bus.core_rsp, 0);
    chk("rst_core_error", bus.core_error, 0);
    chk("rst_core_rdata", bus.core_rdata, 0);
    chk("rst_dev_req", bus.dev_req, 0);
    chk("rst_dev_ack", bus.dev_ack, 0);
    @(posedge g_clk);
    q.delete();
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_unmapped_pulse", bus.unmapped_pulse, 0);
    @(negedge g_clk);
    g_resetn = 1'b1;
  endtask

  initial begin
    g_resetn = 1'b0;
    bus.core_wen = 1'b0; bus.core_strb = '0; bus.core_wdata = '0;
    bus.dev_error = '0; bus.dev_rdata = '0;
    dr[0] = 32'h0D0D_0000;
    dr[1] = 32'hA5A5_0001;
    @(negedge g_clk);
    do_reset();

    // Mapped read to slot 1, answered the following cycle.
    step(1, 32'h1000_1004, 2'b10, 2'b00, 2'b00, 1);
    step(0, 32'h1000_1004, 2'b00, 2'b10, 2'b00, 1);
    chk("read_busy_clear", bus.busy, 0);

    // Slot 1 then slot 0; slot 0 answers early but must wait behind slot 1.
    step(1, 32'h1000_1000, 2'b11, 2'b00, 2'b00, 0);
    step(1, 32'h1000_0000, 2'b11, 2'b01, 2'b00, 1);
    chk("order_ack0_held", bus.dev_ack[0], 0);
    step(0, 32'h1000_0000, 2'b00, 2'b11, 2'b00, 1);
    step(0, 32'h1000_0000, 2'b00, 2'b01, 2'b01, 1);

    // Disabled slot and out-of-window write, each answered with an error.
    step(1, 32'h1000_5000, 2'b00, 2'b00, 2'b00, 0);
    step(0, 32'h1000_5000, 2'b00, 2'b00, 2'b00, 1);
    step(1, 32'h2000_0000, 2'b00, 2'b00, 2'b00, 0);
    step(0, 32'h2000_0000, 2'b00, 2'b00, 2'b00, 1);

    // Fill to DEPTH, stall, pop without bypass, then refill.
    for (int i = 0; i < DEPTH; i++) step(1, (i % 2 == 0) ? 32'h1000_1000 : 32'h1000_0008, 2'b11, 2'b00, 2'b00, 0);
    step(1, 32'h1000_0000, 2'b11, 2'b00, 2'b00, 0);
    step(1, 32'h2000_0000, 2'b11, 2'b11, 2'b00, 1);
    step(1, 32'h1000_0000, 2'b11, 2'b00, 2'b00, 0);
    while (q.size() > 2) step(0, 32'h0, 2'b00, 2'b11, 2'b00, 1);
    step(1, 32'h1000_1000, 2'b11, 2'b11, 2'b00, 1);
    chk("pushpop_busy", bus.busy, 1);
    step(1, 32'h3000_0000, 2'b11, 2'b11, 2'b00, 1);
    while (q.size() > 0) step(0, 32'h0, 2'b00, 2'b11, 2'b10, 1);

    // Reset with three outstanding, then a fresh read.
    for (int i = 0; i < 3; i++) step(1, 32'h1000_0000, 2'b11, 2'b00, 2'b00, 0);
    do_reset();
    step(1, 32'h1000_1000, 2'b11, 2'b00, 2'b00, 0);
    step(0, 32'h1000_1000, 2'b00, 2'b10, 2'b00, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      dr[0] = $urandom;
      dr[1] = $urandom;
      step(1'($urandom_range(0, 1)), rand_addr(), 2'($urandom), 2'($urandom), 2'($urandom),
           1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
